uart_transmitter: RTL and testbench
===================================

# uart_transmitter

UART serial transmitter: the transmit-direction counterpart of the UART/IrDA receive path. Accepts a parallel byte from the host on a one-cycle start strobe and serialises it as start bit, 8 data bits LSB first, an optional parity bit and a stop bit. It holds its own baud counter and bit counter and drives the line idle-high. It sits between the host data source and the line driver or IrDA modulator.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per serial bit (50 MHz / 115200); legal range ≥ 2.
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- tx_start  input  1  request to send; sampled every rising edge.
- tx_data  input  8  byte to send; sampled only in the cycle tx_start is accepted.
- tx_D  output  1  serial line; registered; idle level 1.
- tx_busy  output  1  high from the cycle after acceptance through the last stop-bit cycle.
- tx_done  output  1  one-cycle pulse in the first idle cycle after the stop bit.

## Operation
- One-hot FSM with these states: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - tx_D = 1 and tx_busy = 0.
  - If tx_start = 1, latch tx_data into the shift register, clear the baud and bit counters, and go to START.
- START: tx_D = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA
  - tx_D = shift register bit 0; each bit is held CLKS_PER_BIT cycles, then the register shifts right.
  - The 3-bit bit counter counts 0..7; after bit 7 ends, go to PARITY if the parity feature is compiled in, else STOP.
- PARITY: tx_D = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx_D = 1 for CLKS_PER_BIT cycles, then go to IDLE and assert tx_done for that one cycle.
- Baud counter
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1; the terminal count ends the current bit.
  - Resets to 0 on every state change; no wrap beyond terminal.
- tx_start while tx_busy = 1 is ignored; no queuing. tx_data may change freely after acceptance.
- tx_start in the same cycle tx_done is high is accepted; this gives back-to-back frames.
- Reset
  - Forces IDLE with tx_D = 1, tx_busy = 0, tx_done = 0, and clears the counters and shift register.
  - Asserted mid-frame, the frame is aborted and the line is high from the next edge. No tx_done is produced for the aborted frame.
- Unreachable state codes recover to IDLE on the next edge.

## Timing
- tx_start is accepted at edge N.
  - tx_D falls and tx_busy rises at edge N+1.
  - Start bit covers cycles N+1 .. N+CLKS_PER_BIT.
  - Data bit k starts at edge N+1+(k+1)·CLKS_PER_BIT.
- Frame length F = 10·CLKS_PER_BIT cycles without parity, 11·CLKS_PER_BIT with parity.
- tx_done and tx_busy = 0 occur at edge N+1+F.
- Minimum start-to-start period is F+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined
  - PARITY state is present and sends even parity: XOR of the 8 latched data bits.
  - Frame is 11 bits.
- Undefined
  - PARITY state and parity logic are removed.
  - DATA goes straight to STOP; frame is 10 bits.

## Test plan
All scenarios run with CLKS_PER_BIT = 4.
- Reset and idle
  - Stimulus: hold reset = 0 for 3 cycles, then release; tx_start stays 0.
  - Required: tx_D = 1, tx_busy = 0 and tx_done = 0 throughout 50 cycles.
- Single byte 0xA5, parity off
  - Stimulus: tx_start for one cycle with tx_data = 0xA5.
  - Required: tx_D sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - Required: tx_done pulses once, 41 cycles after acceptance.
- Parity on, bytes 0x03 and 0x07
  - 0x03 → parity bit 0.
  - 0x07 → parity bit 1.
  - Required: frame is 44 cycles.
- Back-to-back frames
  - Stimulus: assert tx_start again in the tx_done cycle with 0x5A.
  - Required: second start bit begins on the next edge with no idle gap; a tx_start pulse mid-frame is ignored and does not corrupt the frame.
- Reset mid-frame
  - Stimulus: assert reset = 0 during data bit 3.
  - Required: tx_D = 1 and tx_busy = 0 at the next edge, and no tx_done.
  - Required: a following 0xFF frame transmits correctly.

Source files
------------

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_transmitter
//  Purpose  : UART serial transmitter. Takes a byte on a one-cycle tx_start
//             strobe and sends start bit, 8 data bits LSB first, an optional
//             even-parity bit and a stop bit. The line idles high.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//  Ports
//    clock    in   1  system clock, rising edge
//    reset    in   1  synchronous, active-low reset
//    tx_start in   1  send request, accepted only while idle
//    tx_data  in   8  byte to send, sampled in the accept cycle
//    tx_D     out  1  registered serial line, idle high
//    tx_busy  out  1  high while a frame is on the line
//    tx_done  out  1  one-cycle pulse in the first idle cycle after stop
//  Build option
//    UART_TX_PARITY_EN : when defined, an even-parity bit follows the data
// ============================================================================
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_D,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int c_BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_BW-1:0] r_baud;
    logic [c_BW-1:0] w_baud_nxt;
    logic [2:0]      r_bit_cnt;
    logic [2:0]      w_bit_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            r_frame_end;
    logic            w_frame_end;
    logic            w_line_nxt;
    logic            w_busy_nxt;
    logic            w_baud_term;
`ifdef UART_TX_PARITY_EN
    logic            r_parity;
    logic            w_parity_nxt;
`endif

    assign w_baud_term = (r_baud == c_BAUD_LAST);

    // Outputs are registered from the current state, so the line lags the
    // state register by one cycle: a start accepted at edge N shows at N+1.
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = w_baud_term ? '0 : r_baud + 1'b1;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_frame_end  = 1'b0;
        w_line_nxt   = 1'b1;
        w_busy_nxt   = 1'b1;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                w_baud_nxt = '0;
                if (tx_start) begin
                    w_state_nxt  = ST_START;
                    w_shift_nxt  = tx_data;
                    w_bit_nxt    = 3'd0;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = ^tx_data;
`endif
                end
            end
            ST_START: begin
                w_line_nxt = 1'b0;
                if (w_baud_term) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_line_nxt = r_shift[0];
                if (w_baud_term) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                w_line_nxt = r_parity;
                if (w_baud_term) begin
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_baud_term) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_end = 1'b1;
                end
            end
            default: begin
                // Illegal or disabled encodings fall back to idle.
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_baud_nxt  = '0;
                w_bit_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_baud      <= '0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_frame_end <= 1'b0;
            tx_D        <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_baud      <= w_baud_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_end <= w_frame_end;
            tx_D        <= w_line_nxt;
            tx_busy     <= w_busy_nxt;
            // Delayed by one so the pulse lands in the first idle cycle.
            tx_done     <= r_frame_end;
`ifdef UART_TX_PARITY_EN
            r_parity    <= w_parity_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_transmitter
//  Purpose  : Self-checking bench for uart_transmitter with CLKS_PER_BIT = 4.
//             A frame-level model predicts line, busy and done every cycle
//             from the accept edge and the byte sent.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int F = NBITS * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_D;
    logic       tx_busy;
    logic       tx_done;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int   cyc        = 0;
    bit   m_active   = 1'b0;
    int   m_n        = 0;
    int   m_done_cyc = -1;
    logic m_bits [0:10];
    int   n_done_obs = 0;
    int   last_done_cyc = -1;
    int   last_accept   = -1;

    uart_transmitter #(.CLKS_PER_BIT(CPB)) u_dut (
        .clock    (clock),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_D     (tx_D),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock edge: update the model from the inputs sampled at the edge,
    // then compare the DUT outputs shortly after.
    task automatic tick();
        logic exp_line, exp_busy, exp_done;
        int   idx;
        @(posedge clock);
        cyc++;
        exp_done = 1'b0;
        if (!reset) begin
            m_active   = 1'b0;
            m_done_cyc = -1;
        end else begin
            exp_done = (cyc == m_done_cyc);
            if (tx_start && (!m_active || cyc > m_n + F)) begin
                m_active   = 1'b1;
                m_n        = cyc;
                m_done_cyc = cyc + F + 1;
                last_accept = cyc;
                m_bits[0] = 1'b0;
                for (int k = 0; k < 8; k++) m_bits[k+1] = tx_data[k];
                m_bits[9]  = (NBITS == 11) ? ^tx_data : 1'b1;
                m_bits[10] = 1'b1;
            end
        end
        if (m_active && cyc >= m_n + 1 && cyc <= m_n + F) begin
            idx      = (cyc - m_n - 1) / CPB;
            exp_line = m_bits[idx];
            exp_busy = 1'b1;
        end else begin
            exp_line = 1'b1;
            exp_busy = 1'b0;
        end
        #1;
        check("tx_D", {31'd0, tx_D}, {31'd0, exp_line});
        check("tx_busy", {31'd0, tx_busy}, {31'd0, exp_busy});
        check("tx_done", {31'd0, tx_done}, {31'd0, exp_done});
        if (tx_done === 1'b1) begin
            n_done_obs++;
            last_done_cyc = cyc;
        end
    endtask

    task automatic send(input logic [7:0] b);
        tx_start = 1'b1;
        tx_data  = b;
        tick();
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int d0;
        int w;
        logic [7:0] rb;

        // Reset and idle
        reset = 1'b0;
        run(3);
        reset = 1'b1;
        run(50);
        check("idle_no_done", n_done_obs, 0);

        // 0xA5: one done pulse, F+1 cycles after acceptance
        d0 = n_done_obs;
        send(8'hA5);
        run(F + 6);
        check("a5_done_count", n_done_obs - d0, 1);
        check("a5_done_latency", last_done_cyc - last_accept, F + 1);

        // 0x03 and 0x07 (parity 0 / 1 when compiled in)
        send(8'h03);
        run(F + 3);
        send(8'h07);
        run(F + 3);

        // Back-to-back: start again in the tx_done cycle with 0x5A,
        // plus an ignored mid-frame start pulse.
        send(8'($urandom));
        w = 0;
        while (tx_done !== 1'b1 && w < F + 10) begin
            tick();
            w++;
        end
        check("b2b_done_seen", {31'd0, tx_done}, 32'd1);
        d0 = n_done_obs;
        send(8'h5A);
        run(15);
        send(8'($urandom));
        run(F + 5);
        check("b2b_done_count", n_done_obs - d0, 1);

        // tx_start held high: frames at minimum spacing
        tx_start = 1'b1;
        for (int i = 0; i < 2 * F + 6; i++) begin
            tx_data = 8'($urandom);
            tick();
        end
        tx_start = 1'b0;
        run(F + 4);

        // Reset during data bit 3, then a clean 0xFF frame
        d0 = n_done_obs;
        send(8'($urandom));
        run(4 * CPB + 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        run(F + 5);
        check("abort_no_done", n_done_obs - d0, 0);
        send(8'hFF);
        run(F + 4);

        // Random traffic
        for (int t = 0; t < 25; t++) begin
            rb = 8'($urandom);
            send(rb);
            for (int i = 0; i < int'($urandom_range(0, F + 8)); i++) begin
                tx_start = ($urandom_range(0, 9) == 0);
                tx_data  = 8'($urandom);
                tick();
            end
            tx_start = 1'b0;
        end
        run(F + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
